// File: rtl/bcd_pkg.sv
// bcd_pkg: shared helpers and scan FSM encodings for display blocks
package bcd_pkg;
  typedef enum logic [1:0] {ST_DISABLED = 2'd0, ST_ON = 2'd1, ST_GAP = 2'd2} scan_state_t;
  function automatic int clogb2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/bcd_slot_timer.sv
// bcd_slot_timer: per-slot cycle counter with clipped lit length and slot-end strobe
module bcd_slot_timer import bcd_pkg::*; #(
  parameter int MULTIPLEX_CLK_COUNT = 10,
  parameter int BLANK_CLK_COUNT = 2,
  localparam int CW = clogb2(MULTIPLEX_CLK_COUNT + 1)
) (
  input  logic          i_clk,
  input  logic          i_clr,
  input  logic          i_load,
  input  logic [CW-1:0] i_bright,
  output logic          o_slot_end,
  output logic          o_on_next
);
  localparam logic [CW-1:0] N_MAX = CW'(MULTIPLEX_CLK_COUNT - BLANK_CLK_COUNT);
  localparam logic [CW-1:0] LAST = CW'(MULTIPLEX_CLK_COUNT - 1);
  logic [CW-1:0] r_cnt, r_n, w_n_new;
  always_comb begin
    w_n_new = (i_bright > N_MAX) ? N_MAX : i_bright;
    o_slot_end = r_cnt == LAST;
    o_on_next = i_load ? (w_n_new != '0) : ((r_cnt + 1'b1) < r_n);
  end
  // counter only advances inside a running slot, so it never reaches M
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_cnt <= '0;
      r_n <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
      r_n <= w_n_new;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/bcd_scan_ctrl.sv
// bcd_scan_ctrl: multiplexed BCD display scanner with brightness, blanking and leading-zero suppression
module bcd_scan_ctrl import bcd_pkg::*; #(
  parameter int DISPLAYS_NUM = 4,
  parameter int DIGIT_W = 4,
  parameter int MULTIPLEX_CLK_COUNT = 10,
  parameter int BLANK_CLK_COUNT = 2,
  parameter int SEL_ACTIVE_LOW = 0,
  localparam int CW = clogb2(MULTIPLEX_CLK_COUNT + 1),
  localparam int IW = clogb2(DISPLAYS_NUM)
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_en,
  input  logic [DISPLAYS_NUM*DIGIT_W-1:0] i_bcd_data,
  input  logic [CW-1:0]                   i_bright,
  input  logic                            i_lz_blank,
  output logic [DIGIT_W-1:0]              o_bcd_muxed,
  output logic [DISPLAYS_NUM-1:0]         o_bcd_sel,
  output logic [IW-1:0]                   o_digit_idx,
  output logic                            o_frame_start
);
  localparam int D = DISPLAYS_NUM;
  localparam int W = DIGIT_W;
  localparam logic [IW-1:0] LAST_IDX = IW'(D - 1);
  localparam logic [D-1:0] SEL_OFF = {D{SEL_ACTIVE_LOW != 0}};
  localparam logic [D-1:0] SEL_ONE = {{(D-1){1'b0}}, 1'b1};
  scan_state_t r_state, w_next_state;
  logic [IW-1:0] r_idx, w_idx_next;
  logic [D*W-1:0] r_shadow, w_shadow_next;
  logic [W-1:0] r_muxed, w_digit;
  logic [D-1:0] r_sel;
  logic r_blank, r_fs, w_blank_next, w_load, w_frame, w_zero_prefix, w_slot_end, w_on_next, w_tmr_clr;
  bcd_slot_timer #(
    .MULTIPLEX_CLK_COUNT(MULTIPLEX_CLK_COUNT),
    .BLANK_CLK_COUNT(BLANK_CLK_COUNT)
  ) u_timer (
    .i_clk(i_clk),
    .i_clr(w_tmr_clr),
    .i_load(w_load),
    .i_bright(i_bright),
    .o_slot_end(w_slot_end),
    .o_on_next(w_on_next)
  );
  always_comb begin
    w_tmr_clr = i_rst || !i_en;
    w_load = i_en && (r_state == ST_DISABLED || w_slot_end);
    w_frame = i_en && (r_state == ST_DISABLED || (w_slot_end && r_idx == LAST_IDX));
    w_next_state = !i_en ? ST_DISABLED : w_on_next ? ST_ON : ST_GAP;
    w_idx_next = (!i_en || w_frame) ? '0 : w_load ? r_idx + 1'b1 : r_idx;
    w_shadow_next = w_frame ? i_bcd_data : r_shadow;
    w_digit = W'(w_shadow_next >> ((D - 1 - int'(w_idx_next)) * W));
    w_zero_prefix = 1'b1;
    for (int j = 0; j < D; j++)
      if (j <= int'(w_idx_next) && w_shadow_next[(D-1-j)*W +: W] != '0) w_zero_prefix = 1'b0;
    w_blank_next = w_load ? (i_lz_blank && w_idx_next != LAST_IDX && w_zero_prefix) : r_blank;
  end
  // outputs are registered from next-cycle values so they line up with the state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_DISABLED;
      r_idx <= '0;
      r_shadow <= '0;
      r_blank <= 1'b0;
      r_fs <= 1'b0;
      r_muxed <= '0;
      r_sel <= SEL_OFF;
    end else begin
      r_state <= w_next_state;
      r_idx <= w_idx_next;
      r_shadow <= w_shadow_next;
      r_blank <= w_blank_next;
      r_fs <= w_frame;
      r_muxed <= i_en ? w_digit : '0;
      r_sel <= SEL_OFF ^ ((w_next_state == ST_ON && !w_blank_next) ? (SEL_ONE << w_idx_next) : '0);
    end
  end
  assign o_bcd_muxed = r_muxed;
  assign o_bcd_sel = r_sel;
  assign o_digit_idx = r_idx;
  assign o_frame_start = r_fs;
endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// tb_bcd_scan_ctrl: directed checks of scan timing, brightness, blanking and reset/abort
module tb_bcd_scan_ctrl;
  logic clk = 1'b0;
  logic rst, en, lz;
  logic [15:0] data;
  logic [3:0] bright;
  logic [3:0] muxed_a, sel_a, muxed_b, sel_b;
  logic [1:0] idx_a, idx_b;
  logic fs_a, fs_b;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  bcd_scan_ctrl dut_a (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_bcd_data(data), .i_bright(bright), .i_lz_blank(lz),
    .o_bcd_muxed(muxed_a), .o_bcd_sel(sel_a), .o_digit_idx(idx_a), .o_frame_start(fs_a)
  );
  bcd_scan_ctrl #(.SEL_ACTIVE_LOW(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_bcd_data(data), .i_bright(bright), .i_lz_blank(lz),
    .o_bcd_muxed(muxed_b), .o_bcd_sel(sel_b), .o_digit_idx(idx_b), .o_frame_start(fs_b)
  );
  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (sel_a !== 4'b0000) begin bad++; $display("FAIL reset_sel got=%b exp=0000", sel_a); end
    total++; if (sel_b !== 4'b1111) begin bad++; $display("FAIL reset_sel_low got=%b exp=1111", sel_b); end
    total++; if (muxed_a !== 4'h0) begin bad++; $display("FAIL reset_muxed got=%h exp=0", muxed_a); end
    total++; if (fs_a !== 1'b0) begin bad++; $display("FAIL reset_fs got=%b exp=0", fs_a); end
    total++; if (idx_a !== 2'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", idx_a); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (sel_a !== 4'b0001) begin bad++; $display("FAIL release_sel got=%b exp=0001", sel_a); end
    total++; if (muxed_a !== 4'h1) begin bad++; $display("FAIL release_muxed got=%h exp=1", muxed_a); end
    total++; if (fs_a !== 1'b1) begin bad++; $display("FAIL release_fs got=%b exp=1", fs_a); end
  endtask
  task automatic test_scan();
    for (int i = 0; i < 80; i++) begin
      int s, c;
      logic [3:0] es;
      s = (i % 40) / 10; c = i % 10;
      es = (c < 8) ? (4'b0001 << s) : 4'b0000;
      total++; if (sel_a !== es) begin bad++; $display("FAIL scan_sel i=%0d got=%b exp=%b", i, sel_a, es); end
      total++; if (sel_b !== ~es) begin bad++; $display("FAIL scan_sel_low i=%0d got=%b exp=%b", i, sel_b, ~es); end
      total++; if (muxed_a !== 4'(s + 1)) begin bad++; $display("FAIL scan_muxed i=%0d got=%h exp=%0d", i, muxed_a, s + 1); end
      total++; if (idx_a !== 2'(s)) begin bad++; $display("FAIL scan_idx i=%0d got=%0d exp=%0d", i, idx_a, s); end
      total++; if (fs_a !== (s == 0 && c == 0)) begin bad++; $display("FAIL scan_fs i=%0d got=%b", i, fs_a); end
      @(negedge clk);
    end
  endtask
  task automatic test_data_change();
    for (int i = 0; i < 80; i++) begin
      int s, ev;
      s = (i % 40) / 10;
      ev = (i < 40) ? s + 1 : s + 5;
      total++; if (muxed_a !== 4'(ev)) begin bad++; $display("FAIL shadow_muxed i=%0d got=%h exp=%0d", i, muxed_a, ev); end
      if (i == 15) data = 16'h5678;
      @(negedge clk);
    end
  endtask
  task automatic test_lz();
    lz = 1'b1; data = 16'h0005;
    repeat (40) @(negedge clk);
    for (int i = 0; i < 80; i++) begin
      int s, c, ev;
      logic [3:0] es;
      s = (i % 40) / 10; c = i % 10;
      es = (s == 3 && c < 8) ? 4'b1000 : 4'b0000;
      ev = (i < 40 && s == 3) ? 5 : 0;
      total++; if (sel_a !== es) begin bad++; $display("FAIL lz_sel i=%0d got=%b exp=%b", i, sel_a, es); end
      total++; if (muxed_a !== 4'(ev)) begin bad++; $display("FAIL lz_muxed i=%0d got=%h exp=%0d", i, muxed_a, ev); end
      if (i == 0) data = 16'h0000;
      @(negedge clk);
    end
  endtask
  task automatic test_bright();
    logic [3:0] bv [4];
    int nl [3];
    bv = '{4'd3, 4'd9, 4'd0, 4'd15};
    nl = '{3, 8, 0};
    lz = 1'b0; data = 16'h1234; bright = bv[0];
    repeat (40) @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 40; i++) begin
        int s, c;
        logic [3:0] es;
        s = i / 10; c = i % 10;
        es = (c < nl[p]) ? (4'b0001 << s) : 4'b0000;
        total++; if (sel_a !== es) begin bad++; $display("FAIL bright_sel p=%0d i=%0d got=%b exp=%b", p, i, sel_a, es); end
        total++; if (idx_a !== 2'(s)) begin bad++; $display("FAIL bright_idx p=%0d i=%0d got=%0d exp=%0d", p, i, idx_a, s); end
        total++; if (fs_a !== (i == 0)) begin bad++; $display("FAIL bright_fs p=%0d i=%0d got=%b", p, i, fs_a); end
        if (i == 39) bright = bv[p + 1];
        @(negedge clk);
      end
    end
  endtask
  task automatic test_abort();
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (sel_b !== 4'b1111) begin bad++; $display("FAIL midrst_sel_low got=%b exp=1111", sel_b); end
    total++; if (idx_b !== 2'd0) begin bad++; $display("FAIL midrst_idx got=%0d exp=0", idx_b); end
    total++; if (muxed_b !== 4'h0) begin bad++; $display("FAIL midrst_muxed got=%h exp=0", muxed_b); end
    total++; if (sel_a !== 4'b0000) begin bad++; $display("FAIL midrst_sel got=%b exp=0000", sel_a); end
    total++; if (fs_b !== 1'b0) begin bad++; $display("FAIL midrst_fs got=%b exp=0", fs_b); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (sel_b !== 4'b1110) begin bad++; $display("FAIL restart_sel_low got=%b exp=1110", sel_b); end
    total++; if (muxed_b !== 4'h1) begin bad++; $display("FAIL restart_muxed got=%h exp=1", muxed_b); end
    total++; if (fs_b !== 1'b1) begin bad++; $display("FAIL restart_fs got=%b exp=1", fs_b); end
    repeat (3) @(negedge clk);
    en = 1'b0;
    repeat (2) begin
      @(negedge clk);
      total++; if (sel_a !== 4'b0000) begin bad++; $display("FAIL dis_sel got=%b exp=0000", sel_a); end
      total++; if (sel_b !== 4'b1111) begin bad++; $display("FAIL dis_sel_low got=%b exp=1111", sel_b); end
      total++; if (idx_a !== 2'd0) begin bad++; $display("FAIL dis_idx got=%0d exp=0", idx_a); end
      total++; if (muxed_a !== 4'h0) begin bad++; $display("FAIL dis_muxed got=%h exp=0", muxed_a); end
      total++; if (fs_a !== 1'b0) begin bad++; $display("FAIL dis_fs got=%b exp=0", fs_a); end
    end
    en = 1'b1;
    @(negedge clk);
    total++; if (fs_a !== 1'b1) begin bad++; $display("FAIL reen_fs got=%b exp=1", fs_a); end
    total++; if (sel_a !== 4'b0001) begin bad++; $display("FAIL reen_sel got=%b exp=0001", sel_a); end
  endtask
  initial begin
    rst = 1'b1; en = 1'b1; lz = 1'b0; data = 16'h1234; bright = 4'd15;
    test_reset();
    test_scan();
    test_data_change();
    test_lz();
    test_bright();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
